ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset, 0xF4 enable) to the attached keyboard.
- Complements the existing PS/2 receive path and shares the PS2_CLK/PS2_DAT open-collector lines with it.
- The top level ties each line low when the corresponding *_oe output is 1, and releases it (high-Z) otherwise.
- The receive path ignores bus activity while busy=1.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- INHIBIT_US, 100, how long the host holds PS2_CLK low before sending, in µs.
- TIMEOUT_US, 15000, maximum time from releasing the clock to the end of the transaction, in µs.
- FILTER_LEN, 8, number of consecutive equal samples required before a PS/2 input change is accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command byte present
- cmd_data  in  8  command byte
- cmd_ready  out  1  block is idle and can accept a command
- ps2_clk_in  in  1  raw PS2_CLK line level
- ps2_dat_in  in  1  raw PS2_DAT line level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_dat_oe  out  1  1 = pull PS2_DAT low
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse when a transaction ends
- status  out  2  valid while done=1: 00 ok, 01 nack, 10 timeout

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. Both lines are released, state goes to IDLE, all counters clear.
- Reset mid-transaction: lines are released in the same cycle (asynchronous); no done pulse is produced.
- Input conditioning:
  - 2-FF synchroniser on each input, then a FILTER_LEN glitch filter.
  - A PS/2 clock falling edge (fe) is a filtered 1→0 transition, one-cycle pulse.
- Handshake: a command is accepted on the cycle where cmd_valid & cmd_ready. cmd_data is latched into shreg, odd parity p = ~^cmd_data is latched, and cmd_ready drops on the next cycle.
- cmd_ready is 1 only in IDLE; busy = !IDLE.
- Timing constants:
  - INH = CLK_HZ/1000000*INHIBIT_US cycles (5000 at default).
  - TO = CLK_HZ/1000000*TIMEOUT_US cycles (750000 at default; 20-bit counter).
- States and transitions:
  - IDLE: both lines released. On accept → INHIBIT.
  - INHIBIT: clk_oe=1, dat_oe=0 for INH cycles. On the last cycle → RTS.
  - RTS: clk_oe=1, dat_oe=1 for exactly 1 cycle. Then → START, clk_oe=0, timeout counter loaded.
  - START: dat_oe=1 (start bit 0). On fe → SHIFT, drive bit0, bitcnt=0.
  - SHIFT:
    - Line value: dat_oe = ~shreg[0].
    - On fe: shift right, bitcnt++.
    - After the fe that completes bit7, drive parity and go to PARITY.
  - PARITY: dat_oe = ~p. On fe → STOP, dat_oe=0 (stop bit 1, line released).
  - STOP: on fe → ACK.
  - ACK: sample the filtered data at the next fe.
    - Data 0 → ack ok.
    - Data 1 → nack.
    - Either way → WAIT_IDLE.
  - WAIT_IDLE: wait until filtered clk=1 and dat=1 → FIN.
  - FIN: done=1 for one cycle with status, then → IDLE.
- Data always changes only on the cycle after an fe, while the device holds the clock low.
- Timeout: if the counter reaches 0 in any state from START through WAIT_IDLE:
  - release both lines;
  - pulse done with status=10;
  - return to IDLE.
  - The timeout takes priority over an fe arriving in the same cycle.
- cmd_valid while busy is ignored and not queued.
- Glitches shorter than FILTER_LEN cycles never generate an fe.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined:
  - A nack or timeout on the first attempt restarts automatically from INHIBIT with the latched byte.
  - Only one retry is made. done pulses once, at the end of the final attempt.
  - status reports the final attempt's result; an extra output retried (1 bit) is high during that done pulse if a retry occurred.
- Undefined: no retry logic, no retried port, and the first failure is reported directly.

Test Plan:
- Send 0xED; device model clocks at 80 µs → line shows 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1. Model acks → done with status=00; clk held low ≥5000 cycles beforehand.
- Send 0xF4 → parity bit 0 sampled by the model. Model returns ack bit 1 → done with status=01.
- Send 0x00 and the model never clocks → after 750000 cycles both oe=0 and done with status=10. With PS2_HOST_TX_RETRY_EN, done occurs only after the second timeout and retried=1.
- Assert reset during the SHIFT of bit 4 → ps2_clk_oe=ps2_dat_oe=0 immediately, no done pulse, cmd_ready=1 after release. A new 0xFF command then completes with status=00.
- Inject a 3-cycle low glitch on ps2_clk_in during SHIFT → no bit advance, and the byte is received intact.
- Hold cmd_valid with 0x55 while busy → ignored; only one transaction occurs and cmd_ready returns 1 the cycle after done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ack check.
// Latency: INH+1 cycles of clock inhibit, then paced by the device clock; done pulses one cycle at the end.
// Backpressure: cmd_ready is high only in IDLE; cmd_valid while busy is dropped. Optional retry: PS2_HOST_TX_RETRY_EN.
module ps2_host_tx #(
  parameter int CLK_HZ     = 50000000,
  parameter int INHIBIT_US = 100,
  parameter int TIMEOUT_US = 15000,
  parameter int FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic [1:0] status
`ifdef PS2_HOST_TX_RETRY_EN
  ,
  output logic       retried
`endif
);

  localparam int INH  = CLK_HZ / 1000000 * INHIBIT_US;
  localparam int TO   = CLK_HZ / 1000000 * TIMEOUT_US;
  localparam int INH_W = $clog2(INH + 1);
  localparam int TO_W  = $clog2(TO + 1);
  localparam int FC_W  = $clog2(FILTER_LEN + 1);

  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FILTER_LEN - 1);

  localparam logic [1:0] ST_OK   = 2'b00;
  localparam logic [1:0] ST_NACK = 2'b01;
  localparam logic [1:0] ST_TO   = 2'b10;

  typedef enum logic [3:0] {
    IDLE, INHIBIT, RTS, START, SHIFT, PARITY, STOP, ACK, WAIT_IDLE, FIN
  } state_t;

  state_t state, nxt;

  // Bit 0 carries the PS/2 clock, bit 1 the PS/2 data.
  logic [1:0]      raw;
  logic [1:0]      sync_a, sync_b, filt;
  logic [FC_W-1:0] fcnt [2];
  logic            clk_d;
  logic            fe;

  logic [7:0]       shreg;
  logic             par;
  logic [2:0]       bitcnt;
  logic [INH_W-1:0] inh_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       stat_q;
  logic             timed;
  logic             to_hit;
  logic             retry_go;

`ifdef PS2_HOST_TX_RETRY_EN
  logic       retry_used;
  logic [7:0] byte_q;
`endif

  assign raw = {ps2_dat_in, ps2_clk_in};

  // Two-flop synchronisers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 2'b11;
      sync_b <= 2'b11;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
    end
  end

  // Glitch filter: a new level is taken only after FILTER_LEN consecutive agreeing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt <= 2'b11;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FC_LAST) begin
          filt[i] <= sync_b[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed filtered clock for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) clk_d <= 1'b1;
    else       clk_d <= filt[0];
  end

  assign fe     = clk_d & ~filt[0];
  assign timed  = state inside {START, SHIFT, PARITY, STOP, ACK, WAIT_IDLE};
  assign to_hit = timed && (to_cnt == '0);

`ifdef PS2_HOST_TX_RETRY_EN
  assign retry_go = ~retry_used & (to_hit | (stat_q == ST_NACK));
`else
  assign retry_go = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic; timeout overrides any edge seen in the same cycle.
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      if (cmd_valid) nxt = INHIBIT;
      INHIBIT:   if (inh_cnt == INH_LAST) nxt = RTS;
      RTS:       nxt = START;
      START:     if (fe) nxt = SHIFT;
      SHIFT:     if (fe && bitcnt == 3'd7) nxt = PARITY;
      PARITY:    if (fe) nxt = STOP;
      STOP:      if (fe) nxt = ACK;
      ACK:       if (fe) nxt = WAIT_IDLE;
      WAIT_IDLE: if (filt == 2'b11) nxt = retry_go ? INHIBIT : FIN;
      FIN:       nxt = IDLE;
      default:   nxt = IDLE;
    endcase
    if (to_hit) nxt = retry_go ? INHIBIT : FIN;
  end

  // Datapath: byte/parity latch, bit shifting, inhibit and timeout counters, result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      par     <= 1'b0;
      bitcnt  <= '0;
      inh_cnt <= '0;
      to_cnt  <= '0;
      stat_q  <= ST_OK;
`ifdef PS2_HOST_TX_RETRY_EN
      retry_used <= 1'b0;
      byte_q     <= '0;
`endif
    end else begin
      inh_cnt <= (state == INHIBIT) ? inh_cnt + 1'b1 : '0;
      if (state == RTS)                to_cnt <= TO_LOAD;
      else if (timed && to_cnt != '0)  to_cnt <= to_cnt - 1'b1;

      if (state == IDLE && cmd_valid) begin
        shreg <= cmd_data;
        par   <= ~^cmd_data;
`ifdef PS2_HOST_TX_RETRY_EN
        byte_q     <= cmd_data;
        retry_used <= 1'b0;
`endif
      end

      if (to_hit) begin
        stat_q <= ST_TO;
      end else begin
        if (state == START && fe) bitcnt <= '0;
        if (state == SHIFT && fe) begin
          shreg  <= {1'b0, shreg[7:1]};
          bitcnt <= bitcnt + 1'b1;
        end
        if (state == ACK && fe) stat_q <= filt[1] ? ST_NACK : ST_OK;
      end

`ifdef PS2_HOST_TX_RETRY_EN
      // Restart with the original byte; shreg has been consumed by the first attempt.
      if (nxt == INHIBIT && state != IDLE) begin
        shreg      <= byte_q;
        retry_used <= 1'b1;
      end
`endif
    end
  end

  // Outputs decode straight from state so a reset releases the lines without waiting for a clock.
  always_comb begin
    cmd_ready  = (state == IDLE);
    busy       = (state != IDLE);
    ps2_clk_oe = (state == INHIBIT) || (state == RTS);
    done       = (state == FIN);
    status     = (state == FIN) ? stat_q : 2'b00;
    case (state)
      RTS, START: ps2_dat_oe = 1'b1;
      SHIFT:      ps2_dat_oe = ~shreg[0];
      PARITY:     ps2_dat_oe = ~par;
      default:    ps2_dat_oe = 1'b0;
    endcase
`ifdef PS2_HOST_TX_RETRY_EN
    retried = (state == FIN) && retry_used;
`endif
  end

endmodule
